// File: rtl/ocx_dlx_tx_lane_que_pkg.sv
// Shared constants and helpers for the DLX transmit lane queue.
package ocx_dlx_tx_pkg;

   localparam int          BLOCK_W       = 64;
   localparam logic [63:0] TS1_PATTERN   = 64'h4B4A4A4A4A4A4A4A;
   localparam logic [47:0] TS2_HEADER    = 48'h4B4545454545;
   localparam logic [47:0] TS3_HEADER    = 48'h4B4141414141;
   localparam logic [39:0] DESKEW_HEADER = 40'h4B1E1E1E1E;

   function automatic logic [7:0] reverse8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/ocx_dlx_tx_lane_que_if.sv
// Valid/ready block handshake between the lane queue and the gearbox.
interface ocx_dlx_tx_lane_que_if;
   import ocx_dlx_tx_pkg::*;

   logic [BLOCK_W-1:0] que_gb_data;
   logic               que_gb_odd;
   logic               que_gb_valid;
   logic               gb_que_ready;

   modport master (output que_gb_data, output que_gb_odd, output que_gb_valid, input gb_que_ready);
   modport slave  (input que_gb_data, input que_gb_odd, input que_gb_valid, output gb_que_ready);
endinterface

// File: rtl/ocx_dlx_tx_lane_que_skid_fifo.sv
// Two-entry in-order skid FIFO; storage is not reset, only pointers and count.
module ocx_dlx_tx_skid_fifo #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             vld,
   output logic             full
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push_ok;
   logic             pop_ok;

   assign vld     = (count != 2'd0);
   assign full    = (count == 2'd2);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & vld;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ocx_dlx_tx_lane_que.sv
// Per-lane transmit queue: pattern/source select, reverse, scramble, parity, skid buffer.
module ocx_dlx_tx_lane_que
   import ocx_dlx_tx_pkg::*;
#(
   parameter int NUM_NBR         = 3,
   parameter int DESKEW_INTERVAL = 32
) (
   input  logic                     dlx_clk,
   input  logic                     ctl_que_reset,
   input  logic [2:0]               ctl_que_lane,
   input  logic                     ctl_que_tx_ts0,
   input  logic                     ctl_que_tx_ts1,
   input  logic                     ctl_que_tx_ts2,
   input  logic                     ctl_que_tx_ts3,
   input  logic [15:0]              ctl_que_good_lanes,
   input  logic [23:0]              ctl_que_deskew,
   input  logic [63:0]              ctl_que_lane_scrambler,
   output logic                     que_ctl_adv,
   input  logic [NUM_NBR-1:0]       ctl_que_use_neighbor,
   input  logic [63:0]              flt_que_data,
   input  logic                     flt_que_valid,
   output logic                     que_flt_ready,
   input  logic [NUM_NBR*64-1:0]    neighbor_in_data,
   output logic [63:0]              neighbor_out_data,
   ocx_dlx_tx_lane_que_if.master    gb
);

   localparam int                CNT_W   = $clog2(DESKEW_INTERVAL);
   localparam logic [CNT_W-1:0]  TS_LAST = CNT_W'(DESKEW_INTERVAL - 1);

   logic               training;
   logic               full;
   logic               enq_p0;
   logic               deq_p1;
   logic [CNT_W-1:0]   ts_count;
   logic [63:0]        pattern_p0;
   logic [63:0]        next_p0;
   logic [63:0]        rev_p0;
   logic [64:0]        word_p0;
   logic [64:0]        head_p1;
   logic               vld_p1;
   logic               unused_deskew_low;

   assign unused_deskew_low = ^ctl_que_deskew[4:0];

   assign training          = ctl_que_tx_ts0 | ctl_que_tx_ts1 | ctl_que_tx_ts2 | ctl_que_tx_ts3;
   assign que_flt_ready     = ~full & ~training & ~ctl_que_reset;
   assign enq_p0            = ~ctl_que_reset & ~full & (training | flt_que_valid);
   assign que_ctl_adv       = enq_p0;
   assign neighbor_out_data = flt_que_data;

   // Training counter wraps so every DESKEW_INTERVAL-th training block is a deskew block
   always_ff @(posedge dlx_clk) begin
      if (ctl_que_reset || !training) ts_count <= '0;
      else if (enq_p0)                ts_count <= (ts_count == TS_LAST) ? '0 : ts_count + 1'b1;
   end

   always_comb begin
      pattern_p0 = '0;
      if (ts_count == TS_LAST)  pattern_p0 = {DESKEW_HEADER, ctl_que_deskew[23:5], 2'b00, ctl_que_lane};
      else if (ctl_que_tx_ts1)  pattern_p0 = TS1_PATTERN;
      else if (ctl_que_tx_ts2)  pattern_p0 = {TS2_HEADER, ctl_que_good_lanes};
      else if (ctl_que_tx_ts3)  pattern_p0 = {TS3_HEADER, ctl_que_good_lanes};
   end

   // Descending scan leaves the lowest-index selected neighbor as the winner
   always_comb begin
      next_p0 = flt_que_data;
      for (int i = NUM_NBR - 1; i >= 0; i--) begin
         if (ctl_que_use_neighbor[i]) next_p0 = neighbor_in_data[64*i +: 64];
      end
      if (training) begin
         for (int b = 0; b < 8; b++) next_p0[8*(7-b) +: 8] = pattern_p0[8*b +: 8];
      end
   end

   always_comb begin
      rev_p0 = '0;
      for (int b = 0; b < 8; b++) rev_p0[8*(7-b) +: 8] = reverse8(next_p0[8*b +: 8]);
      word_p0 = {^next_p0, rev_p0 ^ ctl_que_lane_scrambler};
   end

   // ---- stage p0 -> p1: skid FIFO ----
   assign deq_p1 = vld_p1 & gb.gb_que_ready;

   ocx_dlx_tx_skid_fifo #(.WIDTH(65)) u_fifo (
      .clk     (dlx_clk),
      .rst     (ctl_que_reset),
      .push    (enq_p0),
      .pop     (deq_p1),
      .wr_data (word_p0),
      .rd_data (head_p1),
      .vld     (vld_p1),
      .full    (full)
   );

   assign gb.que_gb_valid = vld_p1;
   assign gb.que_gb_data  = vld_p1 ? head_p1[63:0] : 64'h0;
   assign gb.que_gb_odd   = vld_p1 & head_p1[64];

endmodule

// File: tb/tb_ocx_dlx_tx_lane_que.sv
// Directed plus randomized bench with a queue-based reference model of the lane queue.
module tb_ocx_dlx_tx_lane_que;

   localparam int NBR = 3;
   localparam int DI  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    lane;
   logic          ts0, ts1, ts2, ts3;
   logic [15:0]   good;
   logic [23:0]   deskew;
   logic [63:0]   scr;
   logic          adv;
   logic [NBR-1:0] use_nbr;
   logic [63:0]   flt_data;
   logic          flt_valid;
   logic          flt_ready;
   logic [NBR*64-1:0] nbr_data;
   logic [63:0]   nbr_out;

   int total = 0;
   int bad   = 0;
   logic [64:0] q[$];
   int tsc = 0;

   ocx_dlx_tx_lane_que_if gb ();

   always #5 clk = ~clk;

   ocx_dlx_tx_lane_que #(.NUM_NBR(NBR), .DESKEW_INTERVAL(DI)) dut (
      .dlx_clk                (clk),
      .ctl_que_reset          (rst),
      .ctl_que_lane           (lane),
      .ctl_que_tx_ts0         (ts0),
      .ctl_que_tx_ts1         (ts1),
      .ctl_que_tx_ts2         (ts2),
      .ctl_que_tx_ts3         (ts3),
      .ctl_que_good_lanes     (good),
      .ctl_que_deskew         (deskew),
      .ctl_que_lane_scrambler (scr),
      .que_ctl_adv            (adv),
      .ctl_que_use_neighbor   (use_nbr),
      .flt_que_data           (flt_data),
      .flt_que_valid          (flt_valid),
      .que_flt_ready          (flt_ready),
      .neighbor_in_data       (nbr_data),
      .neighbor_out_data      (nbr_out),
      .gb                     (gb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bitrev(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = b[i];
      return r;
   endfunction

   // Block the spec says gets enqueued this cycle: {odd, data}
   function automatic logic [64:0] exp_word(input logic trn);
      logic [63:0] pat, nxt, dat;
      pat = 64'h0;
      nxt = flt_data;
      if (trn) begin
         if (tsc == DI - 1) pat = {40'h4B1E1E1E1E, deskew[23:5], 2'b00, lane};
         else if (ts1)      pat = 64'h4B4A4A4A4A4A4A4A;
         else if (ts2)      pat = {48'h4B4545454545, good};
         else if (ts3)      pat = {48'h4B4141414141, good};
         for (int b = 0; b < 8; b++) nxt[8*(7-b) +: 8] = pat[8*b +: 8];
      end else begin
         for (int k = 0; k < NBR; k++) begin
            if (use_nbr[k]) begin
               nxt = nbr_data[64*k +: 64];
               break;
            end
         end
      end
      for (int b = 0; b < 8; b++) dat[8*(7-b) +: 8] = bitrev(nxt[8*b +: 8]);
      return {^nxt, dat ^ scr};
   endfunction

   task automatic cycle();
      logic trn, enq;
      logic [64:0] w;
      logic [64:0] head;
      #1;
      trn = ts0 | ts1 | ts2 | ts3;
      enq = !rst && (q.size() < 2) && (trn || flt_valid);
      w   = exp_word(trn);
      chk("adv", 64'(adv), 64'(enq));
      chk("flt_ready", 64'(flt_ready), 64'(!rst && (q.size() < 2) && !trn));
      chk("nbr_out", nbr_out, flt_data);
      @(posedge clk);
      if (rst) begin
         q.delete();
         tsc = 0;
      end else begin
         if (q.size() > 0 && gb.gb_que_ready) void'(q.pop_front());
         if (enq) q.push_back(w);
         if (!trn)     tsc = 0;
         else if (enq) tsc = (tsc + 1) % DI;
      end
      #1;
      head = (q.size() > 0) ? q[0] : 65'h0;
      chk("gb_valid", 64'(gb.que_gb_valid), 64'(q.size() > 0));
      chk("gb_data", gb.que_gb_data, head[63:0]);
      chk("gb_odd", 64'(gb.que_gb_odd), 64'(head[64]));
      chk("ts_count", 64'(dut.ts_count), 64'(tsc));
   endtask

   initial begin
      rst = 1'b1; lane = 3'd5; ts0 = 0; ts1 = 0; ts2 = 0; ts3 = 0;
      good = 16'hA5C3; deskew = 24'hABCDE0; scr = 64'h0; use_nbr = '0;
      flt_data = 64'h0; flt_valid = 1'b0; gb.gb_que_ready = 1'b1;
      nbr_data = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001};

      // reset state
      repeat (2) cycle();
      chk("rst_valid", 64'(gb.que_gb_valid), 64'h0);
      chk("rst_data", gb.que_gb_data, 64'h0);
      chk("rst_flt_ready", 64'(flt_ready), 64'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_flt_ready", 64'(flt_ready), 64'h1);

      // mission mode single block
      flt_data = 64'h1; flt_valid = 1'b1;
      cycle();
      chk("mission_data", gb.que_gb_data, 64'h8000_0000_0000_0000);
      chk("mission_odd", 64'(gb.que_gb_odd), 64'h1);
      flt_valid = 1'b0;
      repeat (2) cycle();

      // ts1 held: deskew on block 31, then drop for a cycle and resume
      ts1 = 1'b1;
      repeat (40) cycle();
      ts1 = 1'b0;
      cycle();
      ts1 = 1'b1;
      repeat (35) cycle();
      ts1 = 1'b0; ts2 = 1'b1;
      repeat (3) cycle();
      ts2 = 1'b0; ts3 = 1'b1;
      repeat (3) cycle();
      ts3 = 1'b0;
      repeat (3) cycle();

      // backpressure then drain
      gb.gb_que_ready = 1'b0; flt_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         flt_data = {$urandom, $urandom};
         cycle();
      end
      chk("bp_full_ready", 64'(flt_ready), 64'h0);
      flt_valid = 1'b0; gb.gb_que_ready = 1'b1;
      repeat (4) cycle();

      // neighbor selection
      flt_valid = 1'b1; use_nbr = 3'b110;
      flt_data = 64'hDEAD_BEEF_0000_0000;
      cycle();
      use_nbr = 3'b000;
      cycle();
      flt_valid = 1'b0;
      repeat (2) cycle();

      // reset with two blocks queued
      gb.gb_que_ready = 1'b0; flt_valid = 1'b1;
      repeat (3) cycle();
      flt_valid = 1'b0; rst = 1'b1;
      cycle();
      chk("midrst_valid", 64'(gb.que_gb_valid), 64'h0);
      chk("midrst_tsc", 64'(dut.ts_count), 64'h0);
      rst = 1'b0; gb.gb_que_ready = 1'b1;
      cycle();

      // all-ones scrambler over the ts0 zero pattern
      ts0 = 1'b1; scr = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      chk("scr_data", gb.que_gb_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("scr_odd", 64'(gb.que_gb_odd), 64'h0);
      repeat (3) cycle();
      ts0 = 1'b0;

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [3:0] tsr;
         tsr = ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'h0;
         {ts3, ts2, ts1, ts0} = tsr;
         rst      = ($urandom_range(0, 39) == 0);
         flt_valid = $urandom_range(0, 1) == 1;
         gb.gb_que_ready = $urandom_range(0, 3) != 0;
         use_nbr  = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
         flt_data = {$urandom, $urandom};
         nbr_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         scr      = {$urandom, $urandom};
         good     = 16'($urandom);
         deskew   = 24'($urandom);
         lane     = 3'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
